// File: rtl/program_loader_pkg.sv
// Shared definitions for the serial program loader: the FSM state encoding,
// the frame sync byte and the default sizing parameters.
// No ports (package).
package program_loader_pkg;

    localparam int unsigned DEFAULT_L     = 16;
    localparam int unsigned DEFAULT_DEPTH = 256;
    localparam int unsigned DEFAULT_AW    = 8;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // States in which the loader is willing to take a byte from the stream.
    function automatic logic accepts_bytes(input state_t s);
        case (s)
            S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
//   InValid/InData/InReady : byte stream, transfer on InValid && InReady
//   MemWrEn/MemAddr/MemData: instruction-memory write port
// Modports: master = stream source / memory side, slave = the loader.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int l  = DEFAULT_L,
    parameter int aw = DEFAULT_AW
) ();

    logic          InValid;
    logic [7:0]    InData;
    logic          InReady;
    logic          MemWrEn;
    logic [aw-1:0] MemAddr;
    logic [l-1:0]  MemData;

    modport master (
        output InValid, InData,
        input  InReady, MemWrEn, MemAddr, MemData
    );

    modport slave (
        input  InValid, InData,
        output InReady, MemWrEn, MemAddr, MemData
    );

endinterface

// File: rtl/loader_checksum.sv
// XOR accumulator for the loader frame checksum.
//   Clk, ResetN : clock, synchronous active-low reset
//   clear       : restart accumulation (start of a new frame)
//   byte_en     : fold data into the accumulator this cycle
//   data        : byte to fold in
//   expected    : received checksum byte to compare against
//   match       : accumulator equals expected
module loader_checksum (
    input  logic       Clk,
    input  logic       ResetN,
    input  logic       clear,
    input  logic       byte_en,
    input  logic [7:0] data,
    input  logic [7:0] expected,
    output logic       match
);

    logic [7:0] acc;

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            acc <= 8'h00;
        end else if (clear) begin
            acc <= 8'h00;
        end else if (byte_en) begin
            acc <= acc ^ data;
        end
    end

    assign match = (acc == expected);

endmodule

// File: rtl/program_loader.sv
// Serial program loader: parses framed bytes (sync, 16-bit word count, words
// high byte first, XOR checksum) and writes the words into instruction memory,
// holding the CPU until a frame with a good checksum has been loaded.
//   Clk, ResetN : clock, synchronous active-low reset
//   Start       : re-arm pulse, honoured only in DONE
//   CpuHold     : holds the CPU PC at 0 while high
//   Done        : program loaded with a good checksum
//   Error       : last frame rejected
//   bus         : byte stream in, instruction-memory write port out
module program_loader
    import program_loader_pkg::*;
#(
    parameter int l     = DEFAULT_L,
    parameter int Depth = DEFAULT_DEPTH,
    parameter int aw    = DEFAULT_AW
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Start,
    output logic              CpuHold,
    output logic              Done,
    output logic              Error,
    program_loader_if.slave   bus
);

    localparam logic [15:0] DEPTH_LIMIT = 16'(Depth);
    localparam logic [aw:0] ONE         = (aw+1)'(1);

    state_t        state, state_next;
    logic          in_ready;
    logic          accepted;
    logic          sync_seen;
    logic [7:0]    len_hi;
    logic [7:0]    data_hi;
    logic [15:0]   frame_len;
    logic          len_bad;
    // One bit wider than the address so a full-depth program does not wrap.
    logic [aw:0]   word_count;
    logic [aw:0]   word_idx;
    logic [aw:0]   word_idx_inc;
    logic          last_word;
    logic          cs_byte_en;
    logic          cs_match;

    assign accepted     = bus.InValid && in_ready;
    assign sync_seen    = accepted && (state == S_IDLE) && (bus.InData == SYNC_BYTE);
    assign frame_len    = {len_hi, bus.InData};
    assign len_bad      = (frame_len == 16'h0000) || (frame_len > DEPTH_LIMIT);
    assign word_idx_inc = word_idx + ONE;
    assign last_word    = (word_idx_inc == word_count);
    assign cs_byte_en   = accepted && ((state == S_LEN_HI) || (state == S_LEN_LO) ||
                                       (state == S_DATA_HI) || (state == S_DATA_LO));

    loader_checksum u_checksum (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .clear    (sync_seen),
        .byte_en  (cs_byte_en),
        .data     (bus.InData),
        .expected (bus.InData),
        .match    (cs_match)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; every byte-consuming state waits for a handshake,
    // so a deasserted InValid simply holds the current state.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (sync_seen) state_next = S_LEN_HI;
            S_LEN_HI:  if (accepted)  state_next = S_LEN_LO;
            S_LEN_LO:  if (accepted)  state_next = len_bad ? S_ERROR : S_DATA_HI;
            S_DATA_HI: if (accepted)  state_next = S_DATA_LO;
            S_DATA_LO: if (accepted)  state_next = last_word ? S_CHECK : S_DATA_HI;
            S_CHECK:   if (accepted)  state_next = cs_match ? S_DONE : S_ERROR;
            S_DONE:    if (Start)     state_next = S_IDLE;
            S_ERROR:                  state_next = S_IDLE;
            default:                  state_next = S_IDLE;
        endcase
    end

    // Datapath: InReady is registered from the next state so it reads 0 while
    // reset is applied and rises on the first clock after reset is released.
    // The memory port only changes on a write, so address/data hold otherwise.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            in_ready    <= 1'b0;
            bus.MemWrEn <= 1'b0;
            bus.MemAddr <= '0;
            bus.MemData <= '0;
            Error       <= 1'b0;
            len_hi      <= 8'h00;
            data_hi     <= 8'h00;
            word_count  <= '0;
            word_idx    <= '0;
        end else begin
            in_ready    <= accepts_bytes(state_next);
            bus.MemWrEn <= 1'b0;

            if (state_next == S_ERROR) begin
                Error <= 1'b1;
            end else if (sync_seen) begin
                Error <= 1'b0;
            end

            if (accepted) begin
                case (state)
                    S_IDLE:    word_idx   <= '0;
                    S_LEN_HI:  len_hi     <= bus.InData;
                    S_LEN_LO:  word_count <= frame_len[aw:0];
                    S_DATA_HI: data_hi    <= bus.InData;
                    S_DATA_LO: begin
                        bus.MemWrEn <= 1'b1;
                        bus.MemAddr <= word_idx[aw-1:0];
                        bus.MemData <= l'({data_hi, bus.InData});
                        word_idx    <= word_idx_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.InReady = in_ready;
    assign Done        = (state == S_DONE);
    assign CpuHold     = (state != S_DONE);

endmodule
